// File: rtl/lcd_row_streamer.sv
// rtl/lcd_row_streamer.sv - serialises two LCD row images into a command/character byte stream
module lcd_row_streamer #(
  parameter int         ROW_CHARS = 16,
  parameter logic [7:0] CMD_ROW1  = 8'h80,
  parameter logic [7:0] CMD_ROW2  = 8'hC0
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic [8*ROW_CHARS-1:0] row1,
  input  logic [8*ROW_CHARS-1:0] row2,
  output logic                   out_valid,
  output logic                   out_rs,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int IDX_W = (ROW_CHARS > 1) ? $clog2(ROW_CHARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_CHARS - 1);

  typedef enum logic [2:0] {IDLE, CMD1, DATA1, CMD2, DATA2, DONE} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       char_idx, char_idx_next;
  logic [8*ROW_CHARS-1:0] snap1, snap2, shadow1, shadow2;
  logic                   dirty;
  logic                   valid_next, rs_next, busy_next, done_next;
  logic [7:0]             data_next;
  logic                   accept, start;

  // Char 0 sits in the most significant byte of the row image.
  function automatic logic [7:0] char_at(input logic [8*ROW_CHARS-1:0] img,
                                         input logic [IDX_W-1:0] idx);
    return img[8*(ROW_CHARS-1-int'(idx)) +: 8];
  endfunction

  assign accept = out_valid && out_ready;
  assign start  = (state == IDLE) && (dirty || (row1 != shadow1) || (row2 != shadow2));

  // Next-state and next-output decode; outputs are registered so out_ready never reaches them combinationally.
  always_comb begin
    state_next    = state;
    char_idx_next = char_idx;
    valid_next    = out_valid;
    rs_next       = out_rs;
    data_next     = out_data;
    busy_next     = busy;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CMD1;
          valid_next = 1'b1;
          rs_next    = 1'b0;
          data_next  = CMD_ROW1;
          busy_next  = 1'b1;
        end
      end
      CMD1: begin
        if (accept) begin
          state_next    = DATA1;
          char_idx_next = '0;
          rs_next       = 1'b1;
          data_next     = char_at(snap1, '0);
        end
      end
      DATA1: begin
        if (accept) begin
          if (char_idx == LAST_IDX) begin
            state_next    = CMD2;
            char_idx_next = '0;
            rs_next       = 1'b0;
            data_next     = CMD_ROW2;
          end else begin
            char_idx_next = char_idx + 1'b1;
            data_next     = char_at(snap1, char_idx + 1'b1);
          end
        end
      end
      CMD2: begin
        if (accept) begin
          state_next    = DATA2;
          char_idx_next = '0;
          rs_next       = 1'b1;
          data_next     = char_at(snap2, '0);
        end
      end
      DATA2: begin
        if (accept) begin
          if (char_idx == LAST_IDX) begin
            state_next    = DONE;
            char_idx_next = '0;
            valid_next    = 1'b0;
            rs_next       = 1'b0;
            data_next     = 8'h00;
            busy_next     = 1'b0;
            done_next     = 1'b1;
          end else begin
            char_idx_next = char_idx + 1'b1;
            data_next     = char_at(snap2, char_idx + 1'b1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, index and output registers.
  always_ff @(posedge clk) begin
    if (nRst) begin
      state      <= IDLE;
      char_idx   <= '0;
      out_valid  <= 1'b0;
      out_rs     <= 1'b0;
      out_data   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      char_idx   <= char_idx_next;
      out_valid  <= valid_next;
      out_rs     <= rs_next;
      out_data   <= data_next;
      busy       <= busy_next;
      frame_done <= done_next;
    end
  end

  // Snapshot at frame start; shadow only learns the image once a whole frame has gone out.
  always_ff @(posedge clk) begin
    if (nRst) begin
      snap1   <= '0;
      snap2   <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
      dirty   <= 1'b1;
    end else begin
      if (start) begin
        snap1 <= row1;
        snap2 <= row2;
        dirty <= 1'b0;
      end
      if (state == DONE) begin
        shadow1 <= snap1;
        shadow2 <= snap2;
      end
    end
  end
endmodule

// File: tb/tb_lcd_row_streamer.sv
// tb/tb_lcd_row_streamer.sv - directed self-checking bench for lcd_row_streamer
module tb_lcd_row_streamer;
  logic         clk = 1'b0;
  logic         nRst = 1'b1;
  logic [127:0] row1 = '0;
  logic [127:0] row2 = '0;
  logic         out_ready = 1'b0;
  logic         out_valid, out_rs, busy, frame_done;
  logic [7:0]   out_data;

  int total = 0;
  int bad = 0;

  logic [8:0] got [0:63];
  int n_acc, n_done, hold_err, overlap_err, busy_err, first_acc, last_acc;
  bit timed_out;

  lcd_row_streamer dut (
    .clk(clk), .nRst(nRst), .row1(row1), .row2(row2),
    .out_valid(out_valid), .out_rs(out_rs), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected {rs,data} for transfer i of a frame built from r1/r2.
  function automatic logic [8:0] exp_byte(input logic [127:0] r1, input logic [127:0] r2, input int i);
    if (i == 0)  return {1'b0, 8'h80};
    if (i < 17)  return {1'b1, r1[8*(16-i) +: 8]};
    if (i == 17) return {1'b0, 8'hC0};
    return {1'b1, r2[8*(33-i) +: 8]};
  endfunction

  // Collects one frame (until frame_done) and records handshake/status anomalies.
  task automatic run_frame(input int mode, input int chg_a, input logic [127:0] img_a,
                           input int chg_b, input logic [127:0] img_b, input int budget);
    logic pv, pr, prs;
    logic [7:0] pd;
    bit app_a, app_b;
    pv = 0; pr = 0; prs = 0; pd = 0; app_a = 0; app_b = 0;
    n_acc = 0; n_done = 0; hold_err = 0; overlap_err = 0; busy_err = 0;
    first_acc = -1; last_acc = -1; timed_out = 1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      if (pv && pr) begin
        if (n_acc < 64) got[n_acc] = {prs, pd};
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
      end
      if (pv && !pr && (!out_valid || out_rs !== prs || out_data !== pd)) hold_err++;
      if (frame_done && out_valid) overlap_err++;
      if (out_valid && !busy) busy_err++;
      if (frame_done && busy) busy_err++;
      if (chg_a >= 0 && n_acc == chg_a && !app_a) begin row1 = img_a; app_a = 1; end
      if (chg_b >= 0 && n_acc == chg_b && !app_b) begin row1 = img_b; app_b = 1; end
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
      pv = out_valid; pr = out_ready; prs = out_rs; pd = out_data;
      if (frame_done) begin n_done++; timed_out = 0; break; end
    end
  endtask

  task automatic test_reset();
    nRst = 1; out_ready = 1;
    row1 = "WORD:           ";
    row2 = "MISTAKES: 0     ";
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_rs !== 1'b0) begin bad++; $display("FAIL reset_rs: got %b want 0", out_rs); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
  endtask

  task automatic test_first_frame();
    nRst = 0;
    run_frame(0, -1, '0, -1, '0, 200);
    total++; if (timed_out) begin bad++; $display("FAIL first_timeout: got timeout want frame_done"); end
    total++; if (n_acc != 34) begin bad++; $display("FAIL first_count: got %0d want 34", n_acc); end
    total++; if (last_acc - first_acc != 33) begin bad++; $display("FAIL first_b2b: got span %0d want 33", last_acc - first_acc); end
    total++; if (got[1] !== 9'h157) begin bad++; $display("FAIL first_W: got %h want 157", got[1]); end
    total++; if (got[18] !== 9'h14D) begin bad++; $display("FAIL first_M: got %h want 14d", got[18]); end
    total++; if (busy_err != 0 || overlap_err != 0) begin bad++; $display("FAIL first_status: got busy_err=%0d overlap=%0d want 0", busy_err, overlap_err); end
    for (int i = 0; i < 34; i++) begin
      total++;
      if (got[i] !== exp_byte(row1, row2, i)) begin bad++; $display("FAIL first_byte%0d: got %h want %h", i, got[i], exp_byte(row1, row2, i)); end
    end
  endtask

  task automatic test_idle_hold();
    int vcnt = 0;
    int dcnt = 0;
    int bcnt = 0;
    out_ready = 1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (out_valid) vcnt++;
      if (frame_done) dcnt++;
      if (busy) bcnt++;
    end
    total++; if (vcnt != 0) begin bad++; $display("FAIL idle_valid: got %0d cycles want 0", vcnt); end
    total++; if (dcnt != 0) begin bad++; $display("FAIL idle_done: got %0d pulses want 0", dcnt); end
    total++; if (bcnt != 0) begin bad++; $display("FAIL idle_busy: got %0d cycles want 0", bcnt); end
  endtask

  task automatic test_row2_change();
    row2 = "MISTAKES: 1     ";
    run_frame(0, -1, '0, -1, '0, 200);
    total++; if (n_acc != 34 || timed_out) begin bad++; $display("FAIL chg_count: got %0d timeout=%0b want 34", n_acc, timed_out); end
    total++; if (got[28] !== 9'h131) begin bad++; $display("FAIL chg_char10: got %h want 131", got[28]); end
    for (int i = 0; i < 34; i++) begin
      total++;
      if (got[i] !== exp_byte(row1, row2, i)) begin bad++; $display("FAIL chg_byte%0d: got %h want %h", i, got[i], exp_byte(row1, row2, i)); end
    end
  endtask

  task automatic test_backpressure();
    row1 = "HELLO WORLD 1234";
    run_frame(1, -1, '0, -1, '0, 400);
    total++; if (n_acc != 34 || timed_out) begin bad++; $display("FAIL bp_count: got %0d timeout=%0b want 34", n_acc, timed_out); end
    total++; if (hold_err != 0) begin bad++; $display("FAIL bp_hold: got %0d violations want 0", hold_err); end
    total++; if (busy_err != 0 || overlap_err != 0) begin bad++; $display("FAIL bp_status: got busy_err=%0d overlap=%0d want 0", busy_err, overlap_err); end
    for (int i = 0; i < 34; i++) begin
      total++;
      if (got[i] !== exp_byte(row1, row2, i)) begin bad++; $display("FAIL bp_byte%0d: got %h want %h", i, got[i], exp_byte(row1, row2, i)); end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [127:0] img0, img_b;
    int extra = 0;
    int d1;
    img0  = "ROUND 2         ";
    img_b = "ROUND 4 FINAL   ";
    row1 = img0;
    run_frame(0, 5, "ROUND 3 SKIPPED ", 20, img_b, 200);
    d1 = n_done;
    total++; if (n_acc != 34 || timed_out) begin bad++; $display("FAIL mid1_count: got %0d timeout=%0b want 34", n_acc, timed_out); end
    for (int i = 0; i < 34; i++) begin
      total++;
      if (got[i] !== exp_byte(img0, row2, i)) begin bad++; $display("FAIL mid1_byte%0d: got %h want %h", i, got[i], exp_byte(img0, row2, i)); end
    end
    run_frame(0, -1, '0, -1, '0, 200);
    total++; if (n_acc != 34 || timed_out) begin bad++; $display("FAIL mid2_count: got %0d timeout=%0b want 34", n_acc, timed_out); end
    for (int i = 0; i < 34; i++) begin
      total++;
      if (got[i] !== exp_byte(img_b, row2, i)) begin bad++; $display("FAIL mid2_byte%0d: got %h want %h", i, got[i], exp_byte(img_b, row2, i)); end
    end
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (frame_done) extra++;
    end
    total++; if (d1 + n_done + extra != 2) begin bad++; $display("FAIL mid_pulses: got %0d want 2", d1 + n_done + extra); end
  endtask

  task automatic test_reset_mid_frame();
    int acc = 0;
    bit hit = 0;
    out_ready = 1;
    row1 = "RESET TEST ROW 1";
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (acc == 12) begin nRst = 1; hit = 1; end
        else acc++;
      end
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_reach: got %0d transfers want 12", acc); end
    @(posedge clk); #1;
    nRst = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", out_data); end
    run_frame(0, -1, '0, -1, '0, 200);
    total++; if (n_acc != 34 || timed_out) begin bad++; $display("FAIL rst_count: got %0d timeout=%0b want 34", n_acc, timed_out); end
    total++; if (got[0] !== 9'h080) begin bad++; $display("FAIL rst_first: got %h want 080", got[0]); end
    for (int i = 0; i < 34; i++) begin
      total++;
      if (got[i] !== exp_byte(row1, row2, i)) begin bad++; $display("FAIL rst_byte%0d: got %h want %h", i, got[i], exp_byte(row1, row2, i)); end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_idle_hold();
    test_row2_change();
    test_backpressure();
    test_mid_frame_change();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
